key_sequence_tx: RTL and testbench
==================================

// Module: key_sequence_tx
// PURPOSE
//   Transmit side of the keypad command protocol: serialises a parallel command
//   (tens digit, units digit, motor bit, presence bit) into the keycode token stream
//   A,D,C,U,C,M,C,P,C,B,C on tvalida/esnumero.
//   Drives the command parser in loopback/self-test and from the remote-command
//   path, so configuration need not be typed on the keypad.
// PARAMETERS
//   HOLD_CYCLES  4     cycles each token is held on tvalida with key_valid=1 (>=1)
//   GAP_CYCLES   2     idle cycles after every token, tvalida=IDLE_CODE (>=1)
//   IDLE_CODE    4'hF  code driven between tokens; never a protocol token
// PORTS
//   CLK           in   1  clock, all logic on rising edge
//   Reset         in   1  synchronous, active-high reset
//   start         in   1  request a frame; sampled only in IDLE
//   decenas_in    in   4  tens digit, 0..9
//   unidades_in   in   4  units digit, 0..9
//   motor_in      in   4  motor command; only bit 0 used
//   presencia_in  in   4  presence command; only bit 0 used
//   tvalida       out  4  current keycode (registered)
//   esnumero      out  1  1 when key_valid=1 and tvalida<=9 (registered)
//   key_valid     out  1  1 while a token is held
//   busy          out  1  1 from the cycle after start is accepted until done
//   done          out  1  one-cycle pulse: frame complete
//   err           out  1  one-cycle pulse: start rejected (digit >9)
// BEHAVIOUR
//   Reset: state IDLE; tvalida=IDLE_CODE; esnumero, key_valid, busy, done, err = 0;
//     token index and timer = 0.
//   Reset mid-frame: outputs return to reset values at the next edge. No partial
//     frame resumes.
//   States: IDLE, SEND, GAP, FINISH.
//   IDLE, start=1, decenas_in<=9 and unidades_in<=9:
//     - latch all four inputs; motor/presencia reduced to {3'b0,in[0]}
//     - idx=0, go to SEND; busy=1 and first token on tvalida at the next edge
//   IDLE, start=1, either digit >9: err=1 for one cycle, stay IDLE, nothing latched.
//   SEND: tvalida=token[idx], key_valid=1, esnumero per rule above.
//     After HOLD_CYCLES cycles go to GAP.
//   GAP: tvalida=IDLE_CODE, key_valid=0, esnumero=0. After GAP_CYCLES cycles:
//     - idx<10: idx++, go to SEND
//     - idx==10: go to FINISH
//   FINISH: done=1 and busy=0 for one cycle, then IDLE. start in FINISH is ignored.
//   Token table, idx 0..10: A(4'hA), D, C(4'hC), U, C, M, C, P, C, B(4'hB), C.
//   start while busy is ignored. Latched values are frozen for the whole frame, so
//     input changes mid-frame have no effect.
//   Frame length: 11*(HOLD_CYCLES+GAP_CYCLES) cycles of SEND/GAP, then 1 FINISH cycle.
//   Timer width: $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). idx width: 4 bits.
//   No two adjacent tokens are separated without an IDLE_CODE gap, so a level-
//     sensitive receiver advances exactly one step per token.
// STRUCTURE
//   Shared package keypad_pkg:
//     - KEY_A=4'hA, KEY_B=4'hB, KEY_C=4'hC, KEY_IDLE=4'hF
//     - NUM_TOKENS=11
//     - state enum tx_state_t {IDLE,SEND,GAP,FINISH}
//   One sub-module key_token_mux: combinational idx + latched fields -> token code.
//   Top holds the FSM, timer, latches and output registers.
// TESTING
//   T1 reset: hold Reset 3 cycles -> tvalida=4'hF; key_valid, esnumero, busy, done,
//      err all 0.
//   T2 frame 4,7,motor=1,pres=0, defaults -> token sequence A,4,C,7,C,1,C,0,C,B,C;
//      each token 4 cycles with esnumero=1 only on 4,7,1,0; 2 idle cycles between;
//      done pulses exactly 67 cycles after the start edge.
//   T3 start with decenas_in=4'hC -> err=1 one cycle; busy stays 0;
//      tvalida stays 4'hF.
//   T4 start re-pulsed at token 5 with new inputs -> frame unchanged.
//      start in the FINISH cycle -> ignored, no new frame.
//   T5 Reset asserted during token P -> next cycle idle outputs, busy=0.
//      Then start 9,0,0,1 -> full correct frame.
//   T6 loopback into the command parser: frame 2,5,1,1 -> parser outputs
//      decenas=2, unidades=5, motor=1, presencia=1 in turn; enable_FSM1 pulses.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad command protocol: keycodes, frame length
// and the transmit-side state encoding.
package keypad_pkg;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_IDLE = 4'hF;

  localparam int         NUM_TOKENS = 11;
  localparam int         IDX_W      = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TOKENS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    FINISH
  } tx_state_t;

  // A keycode is a numeric key when it falls in 0..9.
  function automatic logic isDigit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/key_token_mux.sv
// Maps a token index plus the latched command fields onto the keycode for
// that position of the frame A,D,C,U,C,M,C,P,C,B,C.
module key_token_mux
  import keypad_pkg::*;
#(
  parameter logic [3:0] IDLE_CODE = KEY_IDLE
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic [3:0]       decenas_i,
  input  logic [3:0]       unidades_i,
  input  logic [3:0]       motor_i,
  input  logic [3:0]       presencia_i,
  output logic [3:0]       token_o
);

  // Select the keycode for the requested frame position.
  always_comb begin
    token_o = IDLE_CODE;
    case (idx_i)
      4'd0:  token_o = KEY_A;
      4'd1:  token_o = decenas_i;
      4'd3:  token_o = unidades_i;
      4'd5:  token_o = motor_i;
      4'd7:  token_o = presencia_i;
      4'd9:  token_o = KEY_B;
      4'd2, 4'd4, 4'd6, 4'd8, 4'd10: token_o = KEY_C;
      default: token_o = IDLE_CODE;
    endcase
  end

endmodule

// File: rtl/key_sequence_tx.sv
// Transmit side of the keypad command protocol. A parallel command is latched
// on start and replayed as a keycode token stream, each token held for
// HOLD_CYCLES and followed by GAP_CYCLES of IDLE_CODE so a level-sensitive
// receiver advances exactly once per token. All outputs are registered and
// follow the next state, so they change together with the state register.
module key_sequence_tx
  import keypad_pkg::*;
#(
  parameter int         HOLD_CYCLES = 4,
  parameter int         GAP_CYCLES  = 2,
  parameter logic [3:0] IDLE_CODE   = KEY_IDLE
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       start,
  input  logic [3:0] decenas_in,
  input  logic [3:0] unidades_in,
  input  logic [3:0] motor_in,
  input  logic [3:0] presencia_in,
  output logic [3:0] tvalida,
  output logic       esnumero,
  output logic       key_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);

  tx_state_t          state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         dec_q, dec_d;
  logic [3:0]         uni_q, uni_d;
  logic [3:0]         mot_q, mot_d;
  logic [3:0]         pres_q, pres_d;

  logic [3:0]         tvalida_q, tvalida_d;
  logic               esnumero_q, esnumero_d;
  logic               key_valid_q, key_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [3:0]         token;
  logic               unusedBits;

  // Only bit 0 of the motor and presence commands carries information.
  assign unusedBits = ^{motor_in[3:1], presencia_in[3:1]};

  key_token_mux #(
    .IDLE_CODE (IDLE_CODE)
  ) u_token_mux (
    .idx_i       (idx_d),
    .decenas_i   (dec_d),
    .unidades_i  (uni_d),
    .motor_i     (mot_d),
    .presencia_i (pres_d),
    .token_o     (token)
  );

  // Frame sequencing: accept or reject start, time hold/gap phases, step the token index.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    uni_d   = uni_q;
    mot_d   = mot_q;
    pres_d  = pres_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (isDigit(decenas_in) && isDigit(unidades_in)) begin
            dec_d   = decenas_in;
            uni_d   = unidades_in;
            mot_d   = {3'b000, motor_in[0]};
            pres_d  = {3'b000, presencia_in[0]};
            idx_d   = '0;
            timer_d = '0;
            state_d = SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (timer_q == HOLD_LAST) begin
          timer_d = '0;
          state_d = GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            state_d = SEND;
          end else begin
            state_d = FINISH;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    tvalida_d   = IDLE_CODE;
    key_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    if (state_d == SEND) begin
      tvalida_d   = token;
      key_valid_d = 1'b1;
    end
    if ((state_d == SEND) || (state_d == GAP)) begin
      busy_d = 1'b1;
    end
    if (state_d == FINISH) begin
      done_d = 1'b1;
    end
    esnumero_d = key_valid_d && isDigit(tvalida_d);
  end

  // State, timer, latched command and registered outputs; reset abandons any frame.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      dec_q       <= '0;
      uni_q       <= '0;
      mot_q       <= '0;
      pres_q      <= '0;
      tvalida_q   <= IDLE_CODE;
      esnumero_q  <= 1'b0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      dec_q       <= dec_d;
      uni_q       <= uni_d;
      mot_q       <= mot_d;
      pres_q      <= pres_d;
      tvalida_q   <= tvalida_d;
      esnumero_q  <= esnumero_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign tvalida   = tvalida_q;
  assign esnumero  = esnumero_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_key_sequence_tx.sv
// Bench for key_sequence_tx: table of commands (valid frames and rejected
// starts) plus hand-written sequences for restart-while-busy, start during
// FINISH and reset mid-frame. A small receiver decodes the token stream back
// into command fields.
module tb_key_sequence_tx;
  import keypad_pkg::*;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       start;
  logic [3:0] decenas_in;
  logic [3:0] unidades_in;
  logic [3:0] motor_in;
  logic [3:0] presencia_in;
  logic [3:0] tvalida;
  logic       esnumero;
  logic       key_valid;
  logic       busy;
  logic       done;
  logic       err;

  int nCompared   = 0;
  int nMismatched = 0;

  // Receiver model state.
  logic       prevKv = 1'b0;
  int         tokPos = 0;
  int         newPos;
  logic [3:0] rxDec, rxUni, rxMot, rxPres;
  int         rxEnable = 0;

  typedef struct {
    logic [3:0] dec;
    logic [3:0] uni;
    logic [3:0] mot;
    logic [3:0] pres;
    logic       expErr;
  } vec_t;

  vec_t vecs[7];

  localparam logic [8:0] IDLE_VEC = {4'hF, 5'b00000};

  key_sequence_tx dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .start        (start),
    .decenas_in   (decenas_in),
    .unidades_in  (unidades_in),
    .motor_in     (motor_in),
    .presencia_in (presencia_in),
    .tvalida      (tvalida),
    .esnumero     (esnumero),
    .key_valid    (key_valid),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  // Free-running clock, period 10.
  always #5 CLK = ~CLK;

  // Level-sensitive receiver: one step per key_valid rising edge, A restarts the frame.
  always @(negedge CLK) begin
    if (Reset) begin
      prevKv <= 1'b0;
      tokPos <= 0;
    end else begin
      prevKv <= key_valid;
      if (key_valid && !prevKv) begin
        newPos = (tvalida == 4'hA) ? 0 : tokPos + 1;
        tokPos <= newPos;
        case (newPos)
          1: rxDec  <= tvalida;
          3: rxUni  <= tvalida;
          5: rxMot  <= tvalida;
          7: rxPres <= tvalida;
          9: if (tvalida == 4'hB) rxEnable <= rxEnable + 1;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [8:0] outVec();
    return {tvalida, key_valid, esnumero, busy, done, err};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs one frame and checks every cycle against the expected token timeline.
  // restartAt: cycle at which start is pulsed with new inputs mid-frame (0 = never).
  // finishStart: pulse start during the FINISH cycle.
  // abortAt: cycle at which Reset is asserted and the frame abandoned (0 = never).
  task automatic applyStimulus(input logic [3:0] dec, input logic [3:0] uni,
                               input logic [3:0] mot, input logic [3:0] pres,
                               input int restartAt, input bit finishStart,
                               input int abortAt, input string name);
    logic [3:0] tok[11];
    logic [8:0] expv;
    int slot;
    int pos;
    tok = '{4'hA, dec, 4'hC, uni, 4'hC, {3'b000, mot[0]}, 4'hC,
            {3'b000, pres[0]}, 4'hC, 4'hB, 4'hC};
    decenas_in   = dec;
    unidades_in  = uni;
    motor_in     = mot;
    presencia_in = pres;
    start        = 1'b1;
    tick();
    start = 1'b0;
    // Cycle k is the k-th cycle starting at the acceptance edge; done lands in cycle 67.
    for (int k = 1; k <= 70; k++) begin
      slot = (k - 1) / 6;
      pos  = (k - 1) % 6;
      if (k <= 66) begin
        if (pos < 4)
          expv = {tok[slot], 1'b1, (tok[slot] <= 4'd9), 1'b1, 1'b0, 1'b0};
        else
          expv = {4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      end else if (k == 67) begin
        expv = {4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      end else begin
        expv = IDLE_VEC;
      end
      checkOutput($sformatf("%s cycle %0d", name, k), {23'd0, outVec()}, {23'd0, expv});
      if (k == abortAt) begin
        Reset = 1'b1;
        tick();
        checkOutput($sformatf("%s idle after reset", name), {23'd0, outVec()}, {23'd0, IDLE_VEC});
        Reset = 1'b0;
        tick();
        checkOutput($sformatf("%s no resume", name), {23'd0, outVec()}, {23'd0, IDLE_VEC});
        return;
      end
      if (restartAt != 0 && k == restartAt) begin
        decenas_in   = 4'd1;
        unidades_in  = 4'd2;
        motor_in     = ~mot;
        presencia_in = ~pres;
        start        = 1'b1;
      end
      if (restartAt != 0 && k == restartAt + 1) start = 1'b0;
      if (finishStart && k == 67) start = 1'b1;
      if (k == 68) start = 1'b0;
      tick();
    end
  endtask

  // Checks that the receiver reassembled the expected command from the last frame.
  task automatic checkRx(input logic [3:0] dec, input logic [3:0] uni,
                         input logic [3:0] mot, input logic [3:0] pres,
                         input int enableBefore, input string name);
    checkOutput({name, " rx decenas"},   {28'd0, rxDec},  {28'd0, dec});
    checkOutput({name, " rx unidades"},  {28'd0, rxUni},  {28'd0, uni});
    checkOutput({name, " rx motor"},     {28'd0, rxMot},  {28'd0, 3'b000, mot[0]});
    checkOutput({name, " rx presencia"}, {28'd0, rxPres}, {28'd0, 3'b000, pres[0]});
    checkOutput({name, " rx enable"},    rxEnable,        enableBefore + 1);
  endtask

  initial begin
    int enBefore;
    vecs[0] = '{dec: 4'd4, uni: 4'd7, mot: 4'd1, pres: 4'd0, expErr: 1'b0};
    vecs[1] = '{dec: 4'd2, uni: 4'd5, mot: 4'd1, pres: 4'd1, expErr: 1'b0};
    vecs[2] = '{dec: 4'd0, uni: 4'd9, mot: 4'hF, pres: 4'hE, expErr: 1'b0};
    vecs[3] = '{dec: 4'hC, uni: 4'd3, mot: 4'd0, pres: 4'd0, expErr: 1'b1};
    vecs[4] = '{dec: 4'd3, uni: 4'hA, mot: 4'd1, pres: 4'd1, expErr: 1'b1};
    vecs[5] = '{dec: 4'hF, uni: 4'hF, mot: 4'd0, pres: 4'd0, expErr: 1'b1};
    vecs[6] = '{dec: 4'd9, uni: 4'd9, mot: 4'd0, pres: 4'd1, expErr: 1'b0};

    Reset = 1'b1;
    start = 1'b0;
    decenas_in = '0;
    unidades_in = '0;
    motor_in = '0;
    presencia_in = '0;
    repeat (3) tick();
    checkOutput("reset held", {23'd0, outVec()}, {23'd0, IDLE_VEC});
    Reset = 1'b0;
    tick();
    checkOutput("reset released", {23'd0, outVec()}, {23'd0, IDLE_VEC});

    foreach (vecs[i]) begin
      if (vecs[i].expErr) begin
        decenas_in   = vecs[i].dec;
        unidades_in  = vecs[i].uni;
        motor_in     = vecs[i].mot;
        presencia_in = vecs[i].pres;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput($sformatf("vec%0d err pulse", i), {23'd0, outVec()},
                    {23'd0, 4'hF, 5'b00001});
        tick();
        checkOutput($sformatf("vec%0d err cleared", i), {23'd0, outVec()}, {23'd0, IDLE_VEC});
        tick();
        checkOutput($sformatf("vec%0d still idle", i), {23'd0, outVec()}, {23'd0, IDLE_VEC});
      end else begin
        enBefore = rxEnable;
        applyStimulus(vecs[i].dec, vecs[i].uni, vecs[i].mot, vecs[i].pres, 0, 1'b0, 0,
                      $sformatf("vec%0d", i));
        checkRx(vecs[i].dec, vecs[i].uni, vecs[i].mot, vecs[i].pres, enBefore,
                $sformatf("vec%0d", i));
      end
    end

    // Restart during token 5 with new inputs, then start during FINISH.
    enBefore = rxEnable;
    applyStimulus(4'd3, 4'd8, 4'd0, 4'd1, 32, 1'b1, 0, "restart");
    checkRx(4'd3, 4'd8, 4'd0, 4'd1, enBefore, "restart");

    // Reset while token P is held, then a clean frame.
    applyStimulus(4'd6, 4'd6, 4'd1, 4'd0, 0, 1'b0, 44, "abort");
    enBefore = rxEnable;
    applyStimulus(4'd9, 4'd0, 4'd0, 4'd1, 0, 1'b0, 0, "after abort");
    checkRx(4'd9, 4'd0, 4'd0, 4'd1, enBefore, "after abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
